// File: rtl/axi_crossbar_pkg.sv
// Shared types and defaults for the crossbar channel slices.
// Optional skid-buffer stall counter is enabled with AXI_CROSSBAR_SKID_PERF_EN.
package axi_crossbar_pkg;

  localparam int DEFAULT_DATA_BUS_W = 16;
  localparam int DEFAULT_CNT_W      = 16;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_BUSY,
    SKID_FULL
  } skid_state_e;

endpackage

// File: rtl/axi_crossbar_sat_counter.sv
// Saturating up-counter for crossbar performance monitors.
// Holds at all-ones instead of wrapping; cleared only by srst.
module axi_crossbar_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge aclk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/axi_crossbar_skid_buffer.sv
// Backward-registered valid/ready slice: i_ready comes from a flop, a one-entry
// skid register keeps full throughput. Stall counter under AXI_CROSSBAR_SKID_PERF_EN.
module axi_crossbar_skid_buffer
  import axi_crossbar_pkg::*;
#(
  parameter int DATA_BUS_W = DEFAULT_DATA_BUS_W
`ifdef AXI_CROSSBAR_SKID_PERF_EN
  ,
  parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  i_valid,
  input  logic [DATA_BUS_W-1:0] i_data,
  output logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_BUS_W-1:0] o_data,
`ifdef AXI_CROSSBAR_SKID_PERF_EN
  output logic [CNT_W-1:0]      o_stall_cnt,
`endif
  input  logic                  o_ready
);

  skid_state_e           state_reg, state_next;
  logic [DATA_BUS_W-1:0] main_data_reg, main_data_next;
  logic [DATA_BUS_W-1:0] skid_data_reg, skid_data_next;
  logic                  o_valid_reg;
  logic                  i_ready_reg;
  logic                  accept;
  logic                  take;

  assign accept = i_valid & i_ready_reg;
  assign take   = o_valid_reg & o_ready;

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    skid_data_next = skid_data_reg;
    case (state_reg)
      SKID_EMPTY: begin
        if (accept) begin
          state_next     = SKID_BUSY;
          main_data_next = i_data;
        end
      end
      SKID_BUSY: begin
        if (accept && take) begin
          main_data_next = i_data;
        end else if (accept) begin
          state_next     = SKID_FULL;
          skid_data_next = i_data;
        end else if (take) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // i_ready is low here, so only the drain of the held beat can happen
        if (take) begin
          state_next     = SKID_BUSY;
          main_data_next = skid_data_reg;
        end
      end
      default: begin
        state_next = SKID_EMPTY;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_reg     <= SKID_EMPTY;
      main_data_reg <= '0;
      skid_data_reg <= '0;
      o_valid_reg   <= 1'b0;
      i_ready_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      skid_data_reg <= skid_data_next;
      o_valid_reg   <= (state_next != SKID_EMPTY);
      i_ready_reg   <= (state_next != SKID_FULL);
    end
  end

  assign i_ready = i_ready_reg;
  assign o_valid = o_valid_reg;
  assign o_data  = main_data_reg;

`ifdef AXI_CROSSBAR_SKID_PERF_EN
  axi_crossbar_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .aclk (aclk),
    .srst (srst),
    .inc  (o_valid_reg & ~o_ready),
    .cnt  (o_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_axi_crossbar_skid_buffer.sv
// Bench for axi_crossbar_skid_buffer: directed phases plus random traffic checked
// against a 2-deep FIFO reference model. Define AXI_CROSSBAR_SKID_PERF_EN for the counter test.
module tb_axi_crossbar_skid_buffer;

  localparam int DW = 16;
`ifdef AXI_CROSSBAR_SKID_PERF_EN
  localparam int CW = 4;
  localparam int STALL_MAX = (1 << CW) - 1;
  logic [CW-1:0] o_stall_cnt;
  int            mdl_stall = 0;
`endif

  logic          aclk = 1'b0;
  logic          srst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready = 1'b0;
  logic          i_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;

  always #5 aclk = ~aclk;

  axi_crossbar_skid_buffer #(
    .DATA_BUS_W (DW)
`ifdef AXI_CROSSBAR_SKID_PERF_EN
    ,
    .CNT_W      (CW)
`endif
  ) dut (
    .aclk        (aclk),
    .srst        (srst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
`ifdef AXI_CROSSBAR_SKID_PERF_EN
    .o_stall_cnt (o_stall_cnt),
`endif
    .o_ready     (o_ready)
  );

  int vectors_applied = 0;
  int miscompares = 0;

  // Reference model: a FIFO of capacity 2; ready is registered from occupancy.
  logic [DW-1:0] mdl_q[$];
  bit            mdl_i_ready = 1'b0;
  bit            mdl_zero_data = 1'b1;
  bit            started = 1'b0;
  bit            verbose = 1'b1;
  int            accepted = 0;
  int            delivered = 0;

  task automatic check_vec(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step(input bit rst, input bit iv, input logic [DW-1:0] id, input bit ordy);
    bit            acc;
    bit            tk;
    logic [DW-1:0] tdata;
    acc   = 1'b0;
    tk    = 1'b0;
    tdata = '0;
    @(negedge aclk);
    srst    = rst;
    i_valid = iv;
    i_data  = id;
    o_ready = ordy;
    #1;
    // i_ready must not react to input changes between edges
    if (started) check_vec("i_ready_between_edges", 32'(i_ready), 32'(mdl_i_ready));
    @(posedge aclk);
    started = 1'b1;
    if (rst) begin
      mdl_q.delete();
      mdl_i_ready   = 1'b0;
      mdl_zero_data = 1'b1;
`ifdef AXI_CROSSBAR_SKID_PERF_EN
      mdl_stall = 0;
`endif
    end else begin
      tk  = (mdl_q.size() > 0) && ordy;
      acc = iv && mdl_i_ready;
`ifdef AXI_CROSSBAR_SKID_PERF_EN
      if ((mdl_q.size() > 0) && !ordy && (mdl_stall < STALL_MAX)) mdl_stall++;
`endif
      if (tk) begin
        tdata = mdl_q.pop_front();
        delivered++;
      end
      if (acc) begin
        mdl_q.push_back(id);
        accepted++;
      end
      mdl_i_ready   = (mdl_q.size() < 2);
      mdl_zero_data = 1'b0;
    end
    #1;
    check_vec("o_valid", 32'(o_valid), 32'(mdl_q.size() > 0));
    check_vec("i_ready", 32'(i_ready), 32'(mdl_i_ready));
    if (mdl_q.size() > 0) check_vec("o_data", 32'(o_data), 32'(mdl_q[0]));
    else if (mdl_zero_data) check_vec("o_data_reset", 32'(o_data), 32'd0);
`ifdef AXI_CROSSBAR_SKID_PERF_EN
    check_vec("o_stall_cnt", 32'(o_stall_cnt), 32'(mdl_stall));
`endif
    if (verbose)
      $display("t=%0t srst=%0b in=%0b:%04h acc=%0b take=%0b:%04h out_v=%0b out=%04h rdy=%0b",
               $time, rst, iv, id, acc, tk, tdata, o_valid, o_data, i_ready);
  endtask

  initial begin
    int cyc;
    int rand_start;

    // Reset held three cycles with i_valid asserted
    repeat (3) step(1'b1, 1'b1, 16'h5A5A, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_vec("ready_after_reset", 32'(i_ready), 32'd1);

    // Streaming at full rate
    for (int b = 1; b <= 16; b++) step(1'b0, 1'b1, 16'(b), 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_vec("stream_drained_valid", 32'(o_valid), 32'd0);

    // Backpressure fills the skid
    step(1'b0, 1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 1'b1, 16'hBBBB, 1'b0);
    check_vec("bp_full_ready", 32'(i_ready), 32'd0);
    check_vec("bp_full_data", 32'(o_data), 32'hAAAA);
    step(1'b0, 1'b1, 16'hCCCC, 1'b0);
    check_vec("bp_hold_data", 32'(o_data), 32'hAAAA);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_vec("bp_second_data", 32'(o_data), 32'hBBBB);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_vec("bp_ready_back", 32'(i_ready), 32'd1);
    check_vec("bp_empty", 32'(o_valid), 32'd0);

    // Random traffic, 10k accepted beats
    verbose    = 1'b0;
    rand_start = accepted;
    cyc        = 0;
    while ((accepted - rand_start) < 10000 && cyc < 60000) begin
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      cyc++;
    end
    if (cyc >= 60000) check_vec("random_budget_beats", 32'(accepted - rand_start), 32'd10000);
    $display("random phase: %0d beats accepted, %0d delivered in %0d cycles", accepted - rand_start, delivered, cyc);
    verbose = 1'b1;
    repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1);

    // Reset while full drops both beats
    step(1'b0, 1'b1, 16'h1111, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 1'b0);
    check_vec("mid_full_ready", 32'(i_ready), 32'd0);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    check_vec("mid_reset_valid", 32'(o_valid), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_vec("mid_no_emit", 32'(o_valid), 32'd0);
    step(1'b0, 1'b1, 16'h3333, 1'b1);
    check_vec("mid_after_data", 32'(o_data), 32'h3333);
    step(1'b0, 1'b0, 16'h0000, 1'b1);

`ifdef AXI_CROSSBAR_SKID_PERF_EN
    // Stall counter saturation
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b0);
    repeat (20) step(1'b0, 1'b0, 16'h0000, 1'b0);
    check_vec("stall_saturated", 32'(o_stall_cnt), 32'd15);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    check_vec("stall_cleared", 32'(o_stall_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
